cadence_filt_mc: RTL and testbench

//  Multi-channel successor to the single-input cadence glitch filter. Each of NUM_CH raw

---
 rtl/cadence_filt_mc.sv | 148 ++++++++++++++
 tb/tb_cadence_filt_mc.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cadence_filt_mc.sv
// cadence_filt_mc: multi-channel synchroniser, debounce filter, edge pulse and
// rising-edge period measurement for pedal cadence, wheel speed and brake inputs.
// Every channel is independent; only the stability threshold is shared.
module cadence_filt_mc #(
    parameter int         NUM_CH   = 4,
    parameter int         CNT_W    = 16,
    parameter int         PER_W    = 20,
    parameter logic       FAST_SIM = 1'b0,
    parameter logic       INIT_LVL = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       raw,
    input  logic [CNT_W-1:0]        stbl_thresh,
    input  logic                    per_clr,
    output logic [NUM_CH-1:0]       filt,
    output logic [NUM_CH-1:0]       rise,
    output logic [NUM_CH-1:0]       fall,
    output logic [NUM_CH*PER_W-1:0] per,
    output logic [NUM_CH-1:0]       per_vld
);

    localparam logic [CNT_W-1:0] FAST_CAP = CNT_W'(511);
    localparam logic [PER_W-1:0] PER_MAX  = {PER_W{1'b1}};

    logic [NUM_CH-1:0] ff1_q, ff1_d;
    logic [NUM_CH-1:0] ff2_q, ff2_d;
    logic [NUM_CH-1:0] ff3_q, ff3_d;
    logic [NUM_CH-1:0] filt_q, filt_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;
    logic [NUM_CH-1:0] per_vld_q, per_vld_d;
    logic [NUM_CH-1:0] armed_q, armed_d;
    logic [CNT_W-1:0]  stbl_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  stbl_cnt_d [NUM_CH];
    logic [PER_W-1:0]  run_cnt_q  [NUM_CH];
    logic [PER_W-1:0]  run_cnt_d  [NUM_CH];
    logic [PER_W-1:0]  per_q      [NUM_CH];
    logic [PER_W-1:0]  per_d      [NUM_CH];

    logic [CNT_W-1:0]  thr;
    logic [NUM_CH-1:0] chg;
    logic [NUM_CH-1:0] stable;

    // Effective threshold; the fast-sim cap keeps debounce times short in simulation.
    always_comb begin
        thr = stbl_thresh;
        if (FAST_SIM && (stbl_thresh > FAST_CAP)) begin
            thr = FAST_CAP;
        end
    end

    // Per-channel sync chain, stability counter, filter, edge pulses and period tracking.
    always_comb begin
        ff1_d = raw;
        ff2_d = ff1_q;
        ff3_d = ff2_q;
        chg   = ff2_q ^ ff3_q;
        stable    = '0;
        filt_d    = filt_q;
        rise_d    = '0;
        fall_d    = '0;
        per_vld_d = '0;
        armed_d   = armed_q;
        for (int i = 0; i < NUM_CH; i++) begin
            stbl_cnt_d[i] = stbl_cnt_q[i];
            run_cnt_d[i]  = run_cnt_q[i];
            per_d[i]      = per_q[i];

            // >= so that lowering the threshold below the running count releases at once
            stable[i] = (stbl_cnt_q[i] >= thr);

            if (chg[i]) begin
                stbl_cnt_d[i] = '0;
            end else if (!stable[i]) begin
                stbl_cnt_d[i] = stbl_cnt_q[i] + CNT_W'(1);
            end

            if (stable[i]) begin
                filt_d[i] = ff3_q[i];
            end
            rise_d[i] = stable[i] & ff3_q[i] & ~filt_q[i];
            fall_d[i] = stable[i] & ~ff3_q[i] & filt_q[i];

            if (run_cnt_q[i] != PER_MAX) begin
                run_cnt_d[i] = run_cnt_q[i] + PER_W'(1);
            end

            // Clear wins over a coincident rising edge; the last period stays visible.
            if (per_clr) begin
                run_cnt_d[i] = '0;
                armed_d[i]   = 1'b0;
            end else if (rise_d[i]) begin
                run_cnt_d[i] = PER_W'(1);
                if (armed_q[i]) begin
                    per_d[i]     = run_cnt_q[i];
                    per_vld_d[i] = 1'b1;
                end else begin
                    armed_d[i] = 1'b1;
                end
            end
        end
    end

    // State registers; reset releases with filt equal to the sync level so no edge is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q     <= {NUM_CH{INIT_LVL}};
            ff2_q     <= {NUM_CH{INIT_LVL}};
            ff3_q     <= {NUM_CH{INIT_LVL}};
            filt_q    <= {NUM_CH{INIT_LVL}};
            rise_q    <= '0;
            fall_q    <= '0;
            per_vld_q <= '0;
            armed_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                stbl_cnt_q[i] <= '0;
                run_cnt_q[i]  <= '0;
                per_q[i]      <= '0;
            end
        end else begin
            ff1_q     <= ff1_d;
            ff2_q     <= ff2_d;
            ff3_q     <= ff3_d;
            filt_q    <= filt_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            per_vld_q <= per_vld_d;
            armed_q   <= armed_d;
            for (int i = 0; i < NUM_CH; i++) begin
                stbl_cnt_q[i] <= stbl_cnt_d[i];
                run_cnt_q[i]  <= run_cnt_d[i];
                per_q[i]      <= per_d[i];
            end
        end
    end

    assign filt    = filt_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign per_vld = per_vld_q;

    // Pack per-channel periods onto the flat output bus.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_per
        assign per[g*PER_W +: PER_W] = per_q[g];
    end

endmodule

// File: tb/tb_cadence_filt_mc.sv
// Bench for cadence_filt_mc: scoreboard on the default-parameter instance plus
// directed checks on a PER_W=8 instance and a FAST_SIM instance.
module tb_cadence_filt_mc;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int PER_W  = 20;
    localparam longint PER_MAX_M = (64'd1 << PER_W) - 1;
    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_PER  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance
    logic [NUM_CH-1:0]       raw_m;
    logic [CNT_W-1:0]        thr_m;
    logic                    per_clr_m;
    logic [NUM_CH-1:0]       filt_m, rise_m, fall_m, per_vld_m;
    logic [NUM_CH*PER_W-1:0] per_m;

    // narrow period instance
    logic [NUM_CH-1:0]       raw_p;
    logic [CNT_W-1:0]        thr_p;
    logic                    per_clr_p;
    logic [NUM_CH-1:0]       filt_p, rise_p, fall_p, per_vld_p;
    logic [NUM_CH*8-1:0]     per_p;

    // fast-sim instance
    logic [NUM_CH-1:0]       raw_f;
    logic [CNT_W-1:0]        thr_f;
    logic                    per_clr_f;
    logic [NUM_CH-1:0]       filt_f, rise_f, fall_f, per_vld_f;
    logic [NUM_CH*PER_W-1:0] per_f;

    cadence_filt_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PER_W(PER_W)) dut_m (
        .clk(clk), .rst_n(rst_n), .raw(raw_m), .stbl_thresh(thr_m), .per_clr(per_clr_m),
        .filt(filt_m), .rise(rise_m), .fall(fall_m), .per(per_m), .per_vld(per_vld_m));

    cadence_filt_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PER_W(8)) dut_p (
        .clk(clk), .rst_n(rst_n), .raw(raw_p), .stbl_thresh(thr_p), .per_clr(per_clr_p),
        .filt(filt_p), .rise(rise_p), .fall(fall_p), .per(per_p), .per_vld(per_vld_p));

    cadence_filt_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PER_W(PER_W), .FAST_SIM(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .raw(raw_f), .stbl_thresh(thr_f), .per_clr(per_clr_f),
        .filt(filt_f), .rise(rise_f), .fall(fall_f), .per(per_f), .per_vld(per_vld_f));

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int     ch;
        int     kind;
        longint cyc;
        longint val;
    } ev_t;
    ev_t sb_q[$];

    bit     armed_mdl [NUM_CH];
    longint last_rise [NUM_CH];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_to(input longint t);
        for (int i = 0; i < 5000 && cyc < t; i++) @(negedge clk);
    endtask

    // Drive one raw bit of the main instance; when the new level is held long enough
    // the expected filtered edge (and period, if armed) goes on the scoreboard.
    task automatic set_raw(input int ch, input bit v, input bit expect_edge);
        ev_t e;
        longint ecyc;
        raw_m[ch] = v;
        if (expect_edge) begin
            ecyc = cyc + longint'(thr_m) + 4;
            e.ch = ch; e.kind = v ? K_RISE : K_FALL; e.cyc = ecyc; e.val = 0;
            sb_q.push_back(e);
            if (v) begin
                if (armed_mdl[ch]) begin
                    e.kind = K_PER;
                    e.val  = (ecyc - last_rise[ch] > PER_MAX_M) ? PER_MAX_M : ecyc - last_rise[ch];
                    sb_q.push_back(e);
                end
                armed_mdl[ch] = 1'b1;
                last_rise[ch] = ecyc;
            end
        end
    endtask

    task automatic match_event(input int ch, input int kind, input longint val);
        int idx;
        idx = -1;
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].ch == ch && sb_q[i].kind == kind) begin
                idx = i;
                break;
            end
        end
        check($sformatf("expected_event ch%0d kind%0d", ch, kind), longint'(idx >= 0), 1);
        if (idx >= 0) begin
            check($sformatf("event_cycle ch%0d kind%0d", ch, kind), cyc, sb_q[idx].cyc);
            if (kind == K_PER)
                check($sformatf("per_value ch%0d", ch), val, sb_q[idx].val);
            sb_q.delete(idx);
        end
    endtask

    // Pop/compare every edge or period event the main instance produces.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (rise_m[c])    match_event(c, K_RISE, 0);
                if (fall_m[c])    match_event(c, K_FALL, 0);
                if (per_vld_m[c]) match_event(c, K_PER, longint'(per_m[c*PER_W +: PER_W]));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", sb_q.size(), 0);
        tick(3);
    endtask

    task automatic wait_rise_p(output longint c);
        c = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rise_p[0]) begin
                c = cyc;
                break;
            end
        end
        check("p8_rise_seen", longint'(c >= 0), 1);
    endtask

    initial begin
        longint a, b, c0, r1, r2, r3, r4;
        rst_n = 1'b0;
        raw_m = '0; raw_p = '0; raw_f = '0;
        thr_m = 16'd5; thr_p = 16'd2; thr_f = 16'hFFFF;
        per_clr_m = 1'b0; per_clr_p = 1'b0; per_clr_f = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            armed_mdl[c] = 1'b0;
            last_rise[c] = 0;
        end
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // reset state
        check("rst_filt_m", longint'(filt_m), 0);
        check("rst_pulses_m", longint'({rise_m, fall_m, per_vld_m}), 0);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("rst_per_m ch%0d", c), longint'(per_m[c*PER_W +: PER_W]), 0);
        check("rst_filt_p", longint'(filt_p), 0);
        check("rst_filt_f", longint'(filt_f), 0);

        // 1: thr=5, ch0 rises at the 9th edge
        set_raw(0, 1'b1, 1'b1);
        wait_idle();
        check("t1_filt", longint'(filt_m), 1);

        // 2: glitches of 3 and 5 cycles are rejected, 6 cycles passes, then held high
        set_raw(1, 1'b1, 1'b0); tick(3); set_raw(1, 1'b0, 1'b0); tick(20);
        check("t2_glitch3", longint'(filt_m[1]), 0);
        set_raw(1, 1'b1, 1'b0); tick(5); set_raw(1, 1'b0, 1'b0); tick(20);
        check("t2_glitch5", longint'(filt_m[1]), 0);
        set_raw(1, 1'b1, 1'b1); tick(6); set_raw(1, 1'b0, 1'b1); tick(20);
        wait_idle();
        set_raw(1, 1'b1, 1'b1);
        wait_idle();
        check("t2_filt", longint'(filt_m), 3);

        // 3: thr=10, ch2 rising edges 100 cycles apart, three times
        thr_m = 16'd10;
        tick(1);
        for (int k = 0; k < 3; k++) begin
            set_raw(2, 1'b1, 1'b1); tick(50);
            set_raw(2, 1'b0, 1'b1); tick(50);
        end
        wait_idle();
        check("t3_per_ch2", longint'(per_m[2*PER_W +: PER_W]), 100);

        // simultaneous edges on all channels
        thr_m = 16'd3;
        tick(1);
        for (int c = 0; c < NUM_CH; c++) set_raw(c, ~raw_m[c], 1'b1);
        wait_idle();
        check("simul_filt", longint'(filt_m), longint'(raw_m));

        // 4: PER_W=8 saturation and per_clr re-arm
        a = cyc;
        raw_p[0] = 1'b1;
        wait_rise_p(r1);
        check("p8_latency", r1 - a, 6);
        check("p8_first_no_vld", longint'(per_vld_p[0]), 0);
        tick(10); raw_p[0] = 1'b0;
        tick_to(a + 400); raw_p[0] = 1'b1;
        wait_rise_p(r2);
        check("p8_gap", r2 - r1, 400);
        check("p8_sat_vld", longint'(per_vld_p[0]), 1);
        check("p8_sat_per", longint'(per_p[7:0]), 255);
        tick(10); raw_p[0] = 1'b0; tick(30);
        per_clr_p = 1'b1; tick(1); per_clr_p = 1'b0;
        tick_to(a + 800); raw_p[0] = 1'b1;
        wait_rise_p(r3);
        check("p8_clr_no_vld", longint'(per_vld_p[0]), 0);
        check("p8_clr_per_held", longint'(per_p[7:0]), 255);
        tick(10); raw_p[0] = 1'b0;
        tick_to(r3 + 194); raw_p[0] = 1'b1;
        wait_rise_p(r4);
        check("p8_rearm_vld", longint'(per_vld_p[0]), 1);
        check("p8_rearm_per", longint'(per_p[7:0]), 200);
        tick(2);
        check("p8_quiet", longint'({fall_p, per_vld_p}), 0);

        // 5: FAST_SIM caps thr at 511; lowering thr below the running count releases next edge
        b = cyc;
        raw_f[0] = 1'b1;
        c0 = -1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (filt_f[0]) begin
                c0 = cyc;
                break;
            end
        end
        check("fs_latency", c0 - b, 515);
        check("fs_rise", longint'(rise_f[0]), 1);
        thr_f = 16'd200;
        tick(1);
        b = cyc;
        raw_f[1] = 1'b1;
        tick_to(b + 53);
        check("fs_thr200_hold", longint'(filt_f[1]), 0);
        thr_f = 16'd3;
        tick(1);
        check("fs_thr3_filt", longint'(filt_f[1]), 1);
        check("fs_thr3_rise", longint'(rise_f[1]), 1);
        tick(2);
        check("fs_quiet", longint'({fall_f, per_vld_f}), 0);
        check("fs_per", longint'(per_f != '0), 0);

        // 6: all channels toggle, reset hits mid-debounce
        thr_m = 16'd20;
        tick(1);
        for (int c = 0; c < NUM_CH; c++) set_raw(c, ~raw_m[c], 1'b0);
        tick(8);
        rst_n = 1'b0;
        #1;
        check("rst6_filt", longint'(filt_m), 0);
        check("rst6_pulses", longint'({rise_m, fall_m, per_vld_m}), 0);
        check("rst6_per", longint'(per_m != '0), 0);
        raw_m = '0;
        sb_q.delete();
        for (int c = 0; c < NUM_CH; c++) armed_mdl[c] = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(40);
        check("rst6_after_filt", longint'(filt_m), 0);
        check("rst6_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
